branch_resolve_unit: RTL

- Parametrised branch/jump resolution stage for the in-order RISC-V pipeline. Sits at the EX/MEM boundary.
- Evaluates all six RV32I conditional branches plus JAL/JALR and compares each outcome against the fetch-stage prediction.
- Issues a registered one-cycle redirect on mispredict and keeps resolution statistics.
- Optionally hosts a 2-bit-counter branch history table (BHT) read by fetch.

---
 rtl/branch_resolve_unit_pkg.sv | 38 +++
 rtl/branch_resolve_unit_if.sv | 52 +++++
 rtl/branch_resolve_unit_bht.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================
// Package : branch_resolve_unit_pkg
// Shared encodings and helpers for the branch resolution slice.
// Revision: 1.0
// ============================================================
`default_nettype none

package branch_resolve_unit_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t c_bht_reset = 2'b01;
    localparam int       c_link_byte = 4;
    localparam int       c_link_word = 1;

    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'd1;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
// ============================================================
// Interface : branch_resolve_unit_if
// Instruction/prediction inputs and resolution outputs of the stage.
// Revision: 1.0
// ============================================================
`default_nettype none

interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             valid_i;
    logic             stall_i;
    logic             flush_i;
    logic             is_branch_i;
    logic             is_jal_i;
    logic             is_jalr_i;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  pc_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic [XLEN-1:0]  lookup_pc_i;
    logic             lookup_taken_o;
    logic             resolve_valid_o;
    logic             taken_o;
    logic [XLEN-1:0]  link_o;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output valid_i, stall_i, flush_i, is_branch_i, is_jal_i, is_jalr_i,
               funct3_i, rs1_i, rs2_i, imm_i, pc_i, pred_taken_i,
               pred_target_i, lookup_pc_i,
        input  lookup_taken_o, resolve_valid_o, taken_o, link_o, redirect_o,
               redirect_pc_o, branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  valid_i, stall_i, flush_i, is_branch_i, is_jal_i, is_jalr_i,
               funct3_i, rs1_i, rs2_i, imm_i, pc_i, pred_taken_i,
               pred_target_i, lookup_pc_i,
        output lookup_taken_o, resolve_valid_o, taken_o, link_o, redirect_o,
               redirect_pc_o, branch_cnt_o, mispred_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit_bht.sv
// ============================================================
// Module : branch_bht
// Array of 2-bit saturating direction counters; read is combinational.
// Revision: 1.0
// ============================================================
`default_nettype none

module branch_bht
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [IDX_W-1:0] lookup_idx,
    output logic                  lookup_taken,
    input  wire logic             upd_en,
    input  wire logic [IDX_W-1:0] upd_idx,
    input  wire logic             upd_taken
);

    bht_cnt_t r_cnt [DEPTH];

    // Read sees the pre-update value when lookup and update collide.
    assign lookup_taken = r_cnt[lookup_idx][1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= c_bht_reset;
            end
        end else if (upd_en) begin
            r_cnt[upd_idx] <= bht_next(r_cnt[upd_idx], upd_taken);
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================
// Module : branch_resolve_unit
// Resolves RV32I branches/JAL/JALR, registers redirect and statistics.
// Optional BHT enabled by defining BRANCH_PREDICT_EN.
// Revision: 1.0
// ============================================================
`default_nettype none

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int WORD_PC   = 0,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    branch_resolve_unit_if.slave bus
);

    logic             r_resolve_valid;
    logic             r_taken;
    logic [XLEN-1:0]  r_link;
    logic             r_redirect;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_accept;
    logic             w_xfer;
    logic             w_fire;
    logic             w_cond_taken;
    logic             w_cond_valid;
    logic             w_taken;
    logic             w_mispred;
    logic [XLEN-1:0]  w_imm_word;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_link;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_unused_lookup;

    // Anything arriving while a redirect is out is wrong-path.
    assign w_accept = bus.valid_i & ~bus.stall_i & ~bus.flush_i & ~r_redirect;
    assign w_xfer   = bus.is_branch_i | bus.is_jal_i | bus.is_jalr_i;
    assign w_fire   = w_accept & w_xfer;

    always_comb begin
        w_cond_taken = 1'b0;
        w_cond_valid = 1'b1;
        case (bus.funct3_i)
            F3_BEQ:  w_cond_taken = (bus.rs1_i == bus.rs2_i);
            F3_BNE:  w_cond_taken = (bus.rs1_i != bus.rs2_i);
            F3_BLT:  w_cond_taken = ($signed(bus.rs1_i) <  $signed(bus.rs2_i));
            F3_BGE:  w_cond_taken = ($signed(bus.rs1_i) >= $signed(bus.rs2_i));
            F3_BLTU: w_cond_taken = (bus.rs1_i <  bus.rs2_i);
            F3_BGEU: w_cond_taken = (bus.rs1_i >= bus.rs2_i);
            default: w_cond_valid = 1'b0;
        endcase
    end

    assign w_imm_word = {{2{bus.imm_i[XLEN-1]}}, bus.imm_i[XLEN-1:2]};
    assign w_taken    = bus.is_branch_i ? w_cond_taken : (bus.is_jal_i | bus.is_jalr_i);
    assign w_target   = bus.is_jalr_i ? ((bus.rs1_i + bus.imm_i) & ~XLEN'(1))
                      : (bus.pc_i + ((WORD_PC != 0) ? w_imm_word : bus.imm_i));
    assign w_link     = bus.pc_i + ((WORD_PC != 0) ? XLEN'(c_link_word) : XLEN'(c_link_byte));
    assign w_next_pc  = w_taken ? w_target : w_link;

    // Reserved funct3 codes never trigger a refetch.
    assign w_mispred = (bus.is_branch_i & ~w_cond_valid) ? 1'b0 :
                       ((bus.pred_taken_i != w_taken) |
                        (w_taken & (bus.pred_target_i != w_target)) |
                        ((bus.is_jal_i | bus.is_jalr_i) & ~bus.pred_taken_i));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resolve_valid <= 1'b0;
            r_taken         <= 1'b0;
            r_link          <= '0;
            r_redirect      <= 1'b0;
            r_redirect_pc   <= '0;
            r_branch_cnt    <= '0;
            r_mispred_cnt   <= '0;
        end else begin
            r_resolve_valid <= w_fire;
            r_taken         <= w_fire & w_taken;
            r_link          <= w_fire ? w_link : '0;
            r_redirect      <= w_fire & w_mispred;
            r_redirect_pc   <= w_fire ? w_next_pc : '0;
            if (w_fire && r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_fire && w_mispred && r_mispred_cnt != '1) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.resolve_valid_o = r_resolve_valid;
    assign bus.taken_o         = r_taken;
    assign bus.link_o          = r_link;
    assign bus.redirect_o      = r_redirect;
    assign bus.redirect_pc_o   = r_redirect_pc;
    assign bus.branch_cnt_o    = r_branch_cnt;
    assign bus.mispred_cnt_o   = r_mispred_cnt;

    assign w_unused_lookup = ^bus.lookup_pc_i;

`ifdef BRANCH_PREDICT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_update_idx;

    assign w_lookup_idx = (WORD_PC != 0) ? bus.lookup_pc_i[IDX_W-1:0] : bus.lookup_pc_i[IDX_W+1:2];
    assign w_update_idx = (WORD_PC != 0) ? bus.pc_i[IDX_W-1:0]        : bus.pc_i[IDX_W+1:2];

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_idx   (w_lookup_idx),
        .lookup_taken (bus.lookup_taken_o),
        .upd_en       (w_accept & bus.is_branch_i),
        .upd_idx      (w_update_idx),
        .upd_taken    (w_cond_taken)
    );
`else
    localparam int c_unused_bht_depth = BHT_DEPTH;

    assign bus.lookup_taken_o = 1'b0;
`endif

endmodule

`default_nettype wire
